// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter: producer indices and default widths.
// Build with CDB_ARB_FIXED_PRIO_EN defined to select fixed priority instead of round-robin.
package cdb_arbiter_pkg;

  localparam int SRC_ALU     = 0;
  localparam int SRC_BR      = 1;
  localparam int SRC_LSB     = 2;
  localparam int SRC_NUM_DEF = 3;
  localparam int TAG_W_DEF   = 4;
  localparam int DATA_W_DEF  = 32;

  // Index width that stays legal for a single-source configuration.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// One-hot picker over a request vector: round-robin from a start pointer, or a plain
// lowest-index priority encoder when CDB_ARB_FIXED_PRIO_EN is defined.
module rr_pick #(
  parameter int N = 3,
  parameter int W = 2
) (
`ifndef CDB_ARB_FIXED_PRIO_EN
  input  logic [W-1:0] start,
`endif
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);

`ifndef CDB_ARB_FIXED_PRIO_EN
  logic         found;
  logic [W-1:0] pos;

  // NOTE: every output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = W'((int'(start) + k) % N);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end
`else
  // Scanning downward lets the lowest requesting index be the last (winning) assignment.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        idx      = W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per producer, one registered broadcast per cycle.
// Round-robin by default; CDB_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter  int SRC_NUM = SRC_NUM_DEF,
  parameter  int TAG_W   = TAG_W_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  localparam int SRC_W   = idx_w(SRC_NUM)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      clear_in,
  input  logic [SRC_NUM-1:0]        src_valid,
  input  logic [SRC_NUM*TAG_W-1:0]  src_tag,
  input  logic [SRC_NUM*DATA_W-1:0] src_value,
  output logic [SRC_NUM-1:0]        src_ready,
  output logic                      cdb_valid,
  output logic [SRC_W-1:0]          cdb_src,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_value
);

  logic                en;
  logic [SRC_NUM-1:0]  full;
  logic [SRC_NUM-1:0]  pick_grant;
  logic [SRC_NUM-1:0]  grant;
  logic [SRC_NUM-1:0]  accept;
  logic [SRC_W-1:0]    pick_idx;
  logic [TAG_W-1:0]    slot_tag [SRC_NUM];
  logic [DATA_W-1:0]   slot_val [SRC_NUM];

  // Grants only take effect on an enabled, non-flushing edge.
  assign en        = rdy_in & ~clear_in;
  assign grant     = pick_grant & {SRC_NUM{en}};
  assign src_ready = {SRC_NUM{en}} & (~full | grant);
  assign accept    = src_valid & src_ready;

`ifndef CDB_ARB_FIXED_PRIO_EN
  logic [SRC_W-1:0] rr_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_ptr <= '0;
    end else if (|grant) begin
      rr_ptr <= (pick_idx == SRC_W'(SRC_NUM - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  rr_pick #(.N(SRC_NUM), .W(SRC_W)) u_pick (
    .start (rr_ptr),
    .req   (full),
    .grant (pick_grant),
    .idx   (pick_idx)
  );
`else
  rr_pick #(.N(SRC_NUM), .W(SRC_W)) u_pick (
    .req   (full),
    .grant (pick_grant),
    .idx   (pick_idx)
  );
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      full <= '0;
    end else if (clear_in) begin
      full <= '0;
    end else if (rdy_in) begin
      full <= (full & ~grant) | accept;
    end
  end

  // NOTE: slot payloads carry no reset; they are only observed while the matching full bit is set.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < SRC_NUM; i++) begin
      if (accept[i]) begin
        slot_tag[i] <= src_tag[i*TAG_W +: TAG_W];
        slot_val[i] <= src_value[i*DATA_W +: DATA_W];
      end
    end
  end

  // A refilled winner broadcasts its old contents here while the new ones land in the slot.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_valid <= 1'b0;
      cdb_src   <= '0;
      cdb_tag   <= '0;
      cdb_value <= '0;
    end else if (clear_in) begin
      cdb_valid <= 1'b0;
    end else if (rdy_in) begin
      cdb_valid <= |grant;
      if (|grant) begin
        cdb_src   <= pick_idx;
        cdb_tag   <= slot_tag[pick_idx];
        cdb_value <= slot_val[pick_idx];
      end
    end
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the common data bus (CDB) among the execution-side result producers: ALU reservation station, branch unit and load/store buffer. Each producer hands its finished result (ROB entry tag plus value) to the arbiter through a valid/ready handshake into a private one-entry holding slot. The arbiter picks one occupied slot per cycle and drives a registered broadcast to the ROB, the reservation stations and the register file. A flush input discards everything in flight on a branch mispredict.

## Interface
- `SRC_NUM`, default 3: number of producers; index 0 = ALU, 1 = branch, 2 = LSB.
- `TAG_W`, default 4: ROB entry tag width.
- `DATA_W`, default 32: result value width.
- `clk_in`  in  1  clock; all state is updated on the rising edge.
- `rst_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  global enable; low freezes all state.
- `clear_in`  in  1  mispredict flush.
- `src_valid`  in  SRC_NUM  producer i offers a result.
- `src_tag`  in  SRC_NUM*TAG_W  packed tags; source i occupies bits [i*TAG_W +: TAG_W].
- `src_value`  in  SRC_NUM*DATA_W  packed values, same packing scheme.
- `src_ready`  out  SRC_NUM  slot i can accept this cycle.
- `cdb_valid`  out  1  broadcast valid.
- `cdb_src`  out  SRC_W  winning source index, where SRC_W = $clog2(SRC_NUM).
- `cdb_tag`  out  TAG_W  broadcast ROB tag.
- `cdb_value`  out  DATA_W  broadcast value.

## Operation
- Per-source slot: `full[i]`, `tag[i]`, `val[i]`. A slot is loaded at an edge where `src_valid[i] & src_ready[i]`.
- Ready rule: `src_ready[i] = rdy_in & !clear_in & (!full[i] | grant[i])`. A granted slot can be refilled on the same edge, so each source sustains 1 result/cycle while it keeps winning.
- Grant: combinational over `full[]`. At most one grant per cycle.
  - Round-robin order starts at `rr_ptr`.
  - On a grant to source i: `rr_ptr <= (i+1) mod SRC_NUM`.
  - With no grant, `rr_ptr` holds.
- Broadcast register, loaded on every enabled edge:
  - `cdb_valid <= |grant`.
  - If a grant occurred: `cdb_src`, `cdb_tag` and `cdb_value` take the winner's index and slot contents.
  - With no grant, the payload fields hold their previous values.
- `clear_in` high at an edge: all `full <= 0`, `cdb_valid <= 0`. No accept and no grant occur, and `rr_ptr` holds. Flush acts even when `rdy_in` is low.
- `rdy_in` low (and no clear): slots, `rr_ptr` and the broadcast register all hold, and `src_ready = 0`.
- Reset values: `full = 0`, `rr_ptr = 0`, `cdb_valid = 0`, `cdb_src = 0`, `cdb_tag = 0`, `cdb_value = 0`. The `src_ready` output then evaluates to `rdy_in & !clear_in`.

## Timing
- Latency: a result accepted at edge E0 appears on the CDB after edge E1 at the earliest. Each additional losing arbitration round adds one cycle.
- Worst-case wait for an occupied slot under round-robin is SRC_NUM-1 cycles, so there is no starvation.
- All CDB outputs are registered, so there is no combinational path from `src_*` to `cdb_*`.
- The only combinational input-to-output path is `rdy_in` / `clear_in` → `src_ready`.
- Simultaneous refill of slot i and grant of slot i: the old contents go to the CDB and the new contents stay in the slot; no loss or duplication.
- Reset asserted mid-operation: immediate asynchronous clear of all state; any pending results are dropped.

## Configuration
- `CDB_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins (the ALU always beats the branch unit, which beats the LSB). `rr_ptr` is not implemented. A continuously refilled source 0 may starve the others, which is accepted.
- Not defined (default): round-robin as described above.

## Structure
- The shared package (existing `define.v`) holds:
  - `SRC_ALU` = 0, `SRC_BR` = 1, `SRC_LSB` = 2;
  - the default `TAG_W` and `DATA_W` values;
  - the `CDB_ARB_FIXED_PRIO_EN` macro location.
- One sub-module, `rr_pick`: parameterized request vector plus start pointer in, one-hot grant and index out. Under `CDB_ARB_FIXED_PRIO_EN` it degenerates to a priority encoder.
- Slots and the broadcast register live in `cdb_arbiter`.

## Test plan
- Single result: after reset, source 1 offers tag 5, value 0x100 for one cycle → `src_ready[1] = 1`; one cycle after the capture edge, `cdb_valid = 1`, `cdb_src = 1`, `cdb_tag = 5`, `cdb_value = 0x100`; the next cycle `cdb_valid = 0`.
- Three-way contention: all three sources offer at once (tags 1, 2, 3) with `rr_ptr = 0` → the CDB shows tags 1, 2, 3 on three consecutive cycles; `rr_ptr` ends at 0.
- Back-to-back streaming: source 0 alone offers tags 0..7 continuously → `src_ready[0]` stays 1 and the CDB shows tags 0..7 on 8 consecutive cycles.
- Fairness: source 0 streams continuously while source 2 offers tag 9 → tag 9 is broadcast within 2 cycles of capture in round-robin mode; in the `CDB_ARB_FIXED_PRIO_EN` build it is never broadcast while source 0 streams.
- Flush: slots 0 and 2 are full and `cdb_valid = 1`, then `clear_in` is pulsed → the next cycle `cdb_valid = 0`, and with no new input the CDB stays idle.
- Stall and reset: hold `rdy_in = 0` for 3 cycles with slot 1 full → the CDB outputs and `src_ready` are frozen. Then drop `rst_in` low between edges → `cdb_valid` falls to 0 immediately, with no clock edge required.
